// File: rtl/alsu_pkg.sv
// Shared opcode encoding, LED width and the invalid-operation rule for the ALSU pipeline.
package alsu_pkg;

    typedef enum logic [2:0] {
        AND    = 3'd0,
        XOR    = 3'd1,
        ADD    = 3'd2,
        MULT   = 3'd3,
        SHIFT  = 3'd4,
        ROTATE = 3'd5,
        INV6   = 3'd6,
        INV7   = 3'd7
    } opcode_e;

    localparam int LED_W = 16;

    // Reductions only make sense for the bitwise opcodes; anything else with a reduction set is rejected.
    function automatic logic is_invalid(input logic [2:0] opcode,
                                        input logic       red_a,
                                        input logic       red_b);
        return (opcode >= 3'd6) || ((red_a || red_b) && (opcode > 3'd1));
    endfunction

endpackage

// File: rtl/alsu_core.sv
// Combinational ALSU datapath: computes the stage-2 result from the captured beat and the last committed out.
module alsu_core
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter int FULL_ADDER     = 1
) (
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  opcode_e                   opcode,
    input  logic                      cin,
    input  logic                      red_a,
    input  logic                      red_b,
    input  logic                      byp_a,
    input  logic                      byp_b,
    input  logic                      direction,
    input  logic                      serial_in,
    input  logic [2*WIDTH-1:0]        out_q,
    output logic [2*WIDTH-1:0]        result,
    output logic                      invalid
);

    localparam int OW     = 2 * WIDTH;
    localparam bit PRIO_A = (INPUT_PRIORITY == "A");

    logic [OW-1:0]        ext_a;
    logic [OW-1:0]        ext_b;
    logic [OW-1:0]        sum;
    logic signed [OW-1:0] prod;
    logic                 cin_term;
    logic                 pick_a_red;
    logic                 pick_a_byp;

    assign ext_a      = {{WIDTH{a[WIDTH-1]}}, a};
    assign ext_b      = {{WIDTH{b[WIDTH-1]}}, b};
    assign cin_term   = (FULL_ADDER != 0) ? cin : 1'b0;
    assign sum        = ext_a + ext_b + {{(OW-1){1'b0}}, cin_term};
    // A WIDTH x WIDTH signed product always fits in OW bits, so truncating the OW-bit product is exact.
    assign prod       = $signed(ext_a) * $signed(ext_b);
    assign pick_a_red = red_a && (!red_b || PRIO_A);
    assign pick_a_byp = byp_a && (!byp_b || PRIO_A);

    always_comb begin
        result  = '0;
        invalid = 1'b0;
        if (byp_a || byp_b) begin
            result = pick_a_byp ? ext_a : ext_b;
        end else if (is_invalid(opcode, red_a, red_b)) begin
            invalid = 1'b1;
        end else begin
            case (opcode)
                AND: begin
                    if (red_a || red_b)
                        result = {{(OW-1){1'b0}}, pick_a_red ? (&a) : (&b)};
                    else
                        result = {{WIDTH{1'b0}}, a & b};
                end
                XOR: begin
                    if (red_a || red_b)
                        result = {{(OW-1){1'b0}}, pick_a_red ? (^a) : (^b)};
                    else
                        result = {{WIDTH{1'b0}}, a ^ b};
                end
                ADD:    result = sum;
                MULT:   result = prod;
                SHIFT:  result = direction ? {out_q[OW-2:0], serial_in}
                                           : {serial_in, out_q[OW-1:1]};
                ROTATE: result = direction ? {out_q[OW-2:0], out_q[OW-1]}
                                           : {out_q[0], out_q[OW-1:1]};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage valid/ready ALSU: stage 1 captures a beat, stage 2 holds the result, error counter and LED blink.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter int FULL_ADDER     = 1,
    parameter int BLINK_LEN      = 8,
    parameter int ERR_W          = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic [2:0]              opcode,
    input  logic                    cin,
    input  logic                    red_op_A,
    input  logic                    red_op_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic                    direction,
    input  logic                    serial_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WIDTH-1:0]      out,
    output logic                    invalid_flag,
    output logic [ERR_W-1:0]        err_count,
    output logic [LED_W-1:0]        leds
);

    localparam int CNT_W = $clog2(BLINK_LEN + 1);

    logic                    s1_valid;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;
    opcode_e                 s1_opcode;
    logic                    s1_cin;
    logic                    s1_red_a;
    logic                    s1_red_b;
    logic                    s1_byp_a;
    logic                    s1_byp_b;
    logic                    s1_dir;
    logic                    s1_serial;

    logic                    adv;
    logic                    accept;
    logic                    commit;
    logic [2*WIDTH-1:0]      core_result;
    logic                    core_invalid;
    logic [CNT_W-1:0]        blink_cnt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_valid || adv);
    assign accept   = in_valid && in_ready;
    assign commit   = adv && s1_valid;

    always_ff @(posedge clk) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (accept)
            s1_valid <= 1'b1;
        else if (adv)
            s1_valid <= 1'b0;
    end

    // Operand registers carry no reset; they are only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a      <= A;
            s1_b      <= B;
            s1_opcode <= opcode_e'(opcode);
            s1_cin    <= cin;
            s1_red_a  <= red_op_A;
            s1_red_b  <= red_op_B;
            s1_byp_a  <= bypass_A;
            s1_byp_b  <= bypass_B;
            s1_dir    <= direction;
            s1_serial <= serial_in;
        end
    end

    alsu_core #(
        .WIDTH         (WIDTH),
        .INPUT_PRIORITY(INPUT_PRIORITY),
        .FULL_ADDER    (FULL_ADDER)
    ) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .opcode   (s1_opcode),
        .cin      (s1_cin),
        .red_a    (s1_red_a),
        .red_b    (s1_red_b),
        .byp_a    (s1_byp_a),
        .byp_b    (s1_byp_b),
        .direction(s1_dir),
        .serial_in(s1_serial),
        .out_q    (out),
        .result   (core_result),
        .invalid  (core_invalid)
    );

    // out only changes on a real commit so SHIFT/ROTATE always see the last committed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            out_valid    <= 1'b0;
            invalid_flag <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out          <= core_result;
                invalid_flag <= core_invalid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (commit && core_invalid && (err_count != {ERR_W{1'b1}}))
            err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    // A fresh invalid commit restarts the blink window even if one is already running.
    always_ff @(posedge clk) begin
        if (reset)
            blink_cnt <= '0;
        else if (commit && core_invalid)
            blink_cnt <= CNT_W'(BLINK_LEN);
        else if (blink_cnt != '0)
            blink_cnt <= blink_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset)
            leds <= '0;
        else if (blink_cnt != '0)
            leds <= ~leds;
        else
            leds <= '0;
    end

endmodule
